mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Parametrised successor of the multicycle MIPS main controller. Holds its own state register.
//  Adds ADDI, BNE and JAL, a memory wait-state handshake, an illegal-opcode flag and a retired-instruction counter.
//  Sits between the instruction register (op field) and the multicycle datapath muxes/enables.
// PARAMETERS
//  MEM_HANDSHAKE  1   1: FETCH/MEMRD/MEMWR wait for mem_ready; 0: mem_ready is ignored (treated as 1)
//  EXT_ISA        1   1: ADDI/BNE/JAL decoded; 0: those opcodes are illegal
//  CNT_W          16  width of instr_cnt
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  op           in   6      opcode, IR[31:26]; sampled in DECODE
//  mem_ready    in   1      memory access completes this cycle
//  PCWrite      out  1      unconditional PC write
//  PCWriteCond  out  1      conditional PC write (branch)
//  BranchNE     out  1      0: take branch on Zero; 1: take branch on !Zero
//  IorD         out  1      memory address: 0 = PC, 1 = ALUOut
//  MemRead      out  1      memory read strobe
//  MemWrite     out  1      memory write strobe
//  IRWrite      out  1      instruction register load
//  MemToReg     out  2      write-back source: 00 = ALUOut, 01 = MDR, 10 = PC
//  RegDst       out  2      destination register: 00 = rt, 01 = rd, 10 = $31
//  RegWrite     out  1      register file write
//  ALUSrcA      out  1      ALU A: 0 = PC, 1 = A
//  ALUSrcB      out  2      ALU B: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
//  ALUOp        out  2      00 = add, 01 = sub, 10 = funct
//  PCSource     out  2      PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
//  state        out  4      current state (debug)
//  instr_done   out  1      last cycle of an instruction
//  err_illegal  out  1      sticky: an unknown opcode reached DECODE
//  instr_cnt    out  CNT_W  count of retired instructions
// BEHAVIOUR
//  - Reset: state = FETCH, instr_cnt = 0, err_illegal = 0. While rst = 1, all control outputs and instr_done are forced to 0.
//  - Control outputs are a Moore decode of state. The only exception: PCWrite/IRWrite (FETCH), MemWrite (MEMWR) and
//    instr_done (MEMWR) are gated with mem_ready. MemRead is held for the whole wait.
//  - States (4-bit): 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC, 7 ALUWB, 8 BEQ, 9 JUMP,
//    10 ADDI_EX, 11 ADDI_WB, 12 BNE, 13 JAL; 14/15 unused -> FETCH next cycle, err_illegal is set.
//  - Per-state outputs; unlisted outputs are 0:
//    FETCH   MemRead, IRWrite, ALUSrcB=01, PCWrite
//    DECODE  ALUSrcB=11
//    MEMADR / ADDI_EX  ALUSrcA, ALUSrcB=10
//    MEMRD   MemRead, IorD
//    MEMWB   RegWrite, MemToReg=01
//    MEMWR   MemWrite, IorD
//    EXEC    ALUSrcA, ALUOp=10
//    ALUWB   RegWrite, RegDst=01
//    BEQ     ALUSrcA, ALUOp=01, PCWriteCond, PCSource=01
//    BNE     as BEQ, plus BranchNE
//    JUMP    PCWrite, PCSource=10
//    ADDI_WB RegWrite
//    JAL     PCWrite, PCSource=10, RegWrite, RegDst=10, MemToReg=10
//  - Transitions:
//    FETCH -> DECODE when mem_ready, else stay.
//    DECODE: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BEQ; 000010 -> JUMP;
//      001000 -> ADDI_EX; 000101 -> BNE; 000011 -> JAL (last three only when EXT_ISA=1);
//      any other opcode -> FETCH and err_illegal <= 1.
//    MEMADR -> MEMRD (lw) or MEMWR (sw), decided on op.
//    MEMRD -> MEMWB when mem_ready, else stay. MEMWR -> FETCH when mem_ready, else stay.
//    EXEC -> ALUWB; ADDI_EX -> ADDI_WB; MEMWB/ALUWB/ADDI_WB/BEQ/BNE/JUMP/JAL -> FETCH.
//  - instr_done = 1 in MEMWB, MEMWR (gated by mem_ready), ALUWB, ADDI_WB, BEQ, BNE, JUMP, JAL.
//    instr_cnt increments on the following edge and wraps 2^CNT_W-1 -> 0. Illegal opcodes are not counted.
//  - Latency in cycles with mem_ready=1: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j/jal 3.
//    Each wait cycle adds 1.
//  - rst mid-instruction: immediate return to FETCH. A partial instruction is not counted.
//  - op may change at any time; it is only sampled in DECODE and MEMADR.
// STRUCTURE
//  - Package mc_ctrl_pkg: state localparams, opcode constants, and encodings for MemToReg, RegDst, ALUSrcB, ALUOp and PCSource.
//  - Sub-module mc_ctrl_decode: purely combinational, state -> control vector.
//    The top level holds the state register, next-state logic, mem_ready gating, error flag and counter.
// TESTING
//  1. lw, mem_ready=1 -> states 0,1,2,3,4,0; MemToReg=01 and RegWrite in state 4; instr_cnt=1.
//  2. sw, mem_ready low for 2 cycles in MEMWR -> MemWrite=0 while waiting, then 1 for one cycle; total 6 cycles.
//  3. beq then bne -> PCWriteCond=1 in states 8 and 12; BranchNE=0 in 8 and 1 in 12; each takes 3 cycles.
//  4. jal -> state 13 with PCWrite=1, RegDst=10, MemToReg=10, RegWrite=1; returns to FETCH.
//  5. op=111111 -> DECODE then FETCH; err_illegal=1 stays set; instr_cnt unchanged.
//     With EXT_ISA=0, addi gives the same response.
//  6. rst asserted in MEMRD -> state=0 and all controls 0 asynchronously.
//     Counter preload test (CNT_W=4): 16 R-types -> instr_cnt wraps to 0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller: state codes,
// opcodes, mux encodings and the packed control vector.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
    S_BNE     = 4'd12,
    S_JAL     = 4'd13,
    S_RSVD14  = 4'd14,
    S_RSVD15  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mc_ctrl_decode.sv
// Pure Moore decode: current state -> ungated control vector.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0]        state,
  output logic [CTRL_W-1:0] ctrl
);

  ctrl_t c;

  always_comb begin
    c = '0;
    case (state_t'(state))
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.pc_write  = 1'b1;
      end
      S_DECODE: c.alu_src_b = SRCB_IMMSH;
      S_MEMADR, S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = M2R_MDR;
        c.instr_done = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write  = 1'b1;
        c.iord       = 1'b1;
        c.instr_done = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = RDST_RD;
        c.instr_done = 1'b1;
      end
      S_BEQ, S_BNE: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
        c.branch_ne     = (state_t'(state) == S_BNE);
        c.instr_done    = 1'b1;
      end
      S_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCSRC_JUMP;
        c.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_JAL: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCSRC_JUMP;
        c.reg_write  = 1'b1;
        c.reg_dst    = RDST_RA;
        c.mem_to_reg = M2R_PC;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
  end

  assign ctrl = c;

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main controller: state register, next-state logic,
// memory wait-state gating, sticky illegal-opcode flag and retire counter.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int EXT_ISA       = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BranchNE,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       MemToReg,
  output logic [1:0]       RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             err_illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam bit EXT_OK = (EXT_ISA != 0);

  state_t            state_q, state_d;
  logic              set_err;
  logic              ready;
  logic [CTRL_W-1:0] dec_vec;
  ctrl_t             dec, g;

  assign ready = (MEM_HANDSHAKE == 0) || mem_ready;

  mc_ctrl_decode u_decode (
    .state (state_q),
    .ctrl  (dec_vec)
  );

  assign dec = ctrl_t'(dec_vec);

  always_comb begin
    state_d = state_q;
    set_err = 1'b0;
    case (state_q)
      S_FETCH:  if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = EXT_OK ? S_ADDI_EX : S_FETCH;
          OP_BNE:       state_d = EXT_OK ? S_BNE : S_FETCH;
          OP_JAL:       state_d = EXT_OK ? S_JAL : S_FETCH;
          default:      state_d = S_FETCH;
        endcase
        // Anything that falls back to FETCH from DECODE was not decoded.
        set_err = (state_d == S_FETCH);
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (ready) state_d = S_MEMWB;
      S_MEMWR:   if (ready) state_d = S_FETCH;
      S_EXEC:    state_d = S_ALUWB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_MEMWB, S_ALUWB, S_ADDI_WB, S_BEQ, S_BNE, S_JUMP, S_JAL:
                 state_d = S_FETCH;
      default: begin
        state_d = S_FETCH;
        set_err = 1'b1;
      end
    endcase
  end

  // Strobes that complete a memory transfer only fire on the ready cycle;
  // MemRead stays up for the whole wait so the memory sees a stable request.
  always_comb begin
    g = dec;
    if (state_q == S_FETCH) begin
      g.pc_write = dec.pc_write & ready;
      g.ir_write = dec.ir_write & ready;
    end
    if (state_q == S_MEMWR) begin
      g.mem_write  = dec.mem_write & ready;
      g.instr_done = dec.instr_done & ready;
    end
    if (rst) g = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      err_illegal <= 1'b0;
      instr_cnt   <= '0;
    end else begin
      state_q <= state_d;
      if (set_err) err_illegal <= 1'b1;
      if (g.instr_done) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  assign state       = state_q;
  assign PCWrite     = g.pc_write;
  assign PCWriteCond = g.pc_write_cond;
  assign BranchNE    = g.branch_ne;
  assign IorD        = g.iord;
  assign MemRead     = g.mem_read;
  assign MemWrite    = g.mem_write;
  assign IRWrite     = g.ir_write;
  assign MemToReg    = g.mem_to_reg;
  assign RegDst      = g.reg_dst;
  assign RegWrite    = g.reg_write;
  assign ALUSrcA     = g.alu_src_a;
  assign ALUSrcB     = g.alu_src_b;
  assign ALUOp       = g.alu_op;
  assign PCSource    = g.pc_source;
  assign instr_done  = g.instr_done;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: table of instruction vectors checked cycle by cycle
// through a scoreboard queue, plus reset, wait-state and counter-wrap sequences.
module tb_mc_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: defaults (handshake on, extended ISA, 16-bit counter)
  logic        rst, mem_ready;
  logic [5:0]  op;
  logic        PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0]  MemToReg, RegDst, ALUSrcB, ALUOp, PCSource;
  logic        RegWrite, ALUSrcA, instr_done, err_illegal;
  logic [3:0]  state;
  logic [15:0] instr_cnt;

  mc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .state(state), .instr_done(instr_done),
    .err_illegal(err_illegal), .instr_cnt(instr_cnt)
  );

  // Second instance: base ISA only, handshake off, 4-bit counter
  logic       rst2, mem_ready2;
  logic [5:0] op2;
  logic       pcw2, pcc2, bne2, iord2, mrd2, mwr2, irw2, rw2, sa2, done2, err2;
  logic [1:0] m2r2, rd2, sb2, aop2, pcs2;
  logic [3:0] state2, cnt2;

  mc_ctrl_fsm #(.MEM_HANDSHAKE(0), .EXT_ISA(0), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst2), .op(op2), .mem_ready(mem_ready2),
    .PCWrite(pcw2), .PCWriteCond(pcc2), .BranchNE(bne2), .IorD(iord2),
    .MemRead(mrd2), .MemWrite(mwr2), .IRWrite(irw2), .MemToReg(m2r2),
    .RegDst(rd2), .RegWrite(rw2), .ALUSrcA(sa2), .ALUSrcB(sb2),
    .ALUOp(aop2), .PCSource(pcs2), .state(state2), .instr_done(done2),
    .err_illegal(err2), .instr_cnt(cnt2)
  );

  logic [19:0] act_ctl;
  assign act_ctl = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
                    MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done};

  // seq nibble i = expected state in cycle i; rdy bit i = mem_ready in cycle i
  typedef struct packed {
    logic [5:0]      op;
    logic [3:0]      len;
    logic [7:0][3:0] seq;
    logic [7:0]      rdy;
    logic            cnt_inc;
    logic            err;
  } vec_t;

  typedef struct packed {
    logic [3:0]  st;
    logic [19:0] ctl;
  } exp_t;

  exp_t        sbq[$];
  vec_t        vecs[13];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = '0;
  logic        exp_err = 1'b0;

  // Expected control outputs per state, straight from the output table
  function automatic logic [19:0] exp_ctl(input logic [3:0] st, input logic rdy);
    logic pcw, pcc, bne, iord, mrd, mwr, irw, rw, sa, done;
    logic [1:0] m2r, rd, sb, aop, pcs;
    {pcw, pcc, bne, iord, mrd, mwr, irw, rw, sa, done} = '0;
    {m2r, rd, sb, aop, pcs} = '0;
    case (st)
      4'd0:  begin mrd = 1; irw = rdy; pcw = rdy; sb = 2'b01; end
      4'd1:  sb = 2'b11;
      4'd2, 4'd10: begin sa = 1; sb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 2'b01; done = 1; end
      4'd5:  begin mwr = rdy; iord = 1; done = rdy; end
      4'd6:  begin sa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rd = 2'b01; done = 1; end
      4'd8:  begin sa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; done = 1; end
      4'd12: begin sa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; bne = 1; done = 1; end
      4'd9:  begin pcw = 1; pcs = 2'b10; done = 1; end
      4'd11: begin rw = 1; done = 1; end
      4'd13: begin pcw = 1; pcs = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; done = 1; end
      default: ;
    endcase
    return {pcw, pcc, bne, iord, mrd, mwr, irw, m2r, rd, rw, sa, sb, aop, pcs, done};
  endfunction

  function automatic vec_t mkv(input logic [5:0] o, input logic [3:0] n, input logic [31:0] s,
                               input logic [7:0] r, input logic inc, input logic e);
    vec_t v;
    v.op = o; v.len = n; v.seq = s; v.rdy = r; v.cnt_inc = inc; v.err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    exp_t e;
    for (int i = 0; i < int'(v.len); i++)
      sbq.push_back({v.seq[i], exp_ctl(v.seq[i], v.rdy[i])});
    for (int i = 0; i < int'(v.len); i++) begin
      op = v.op;
      mem_ready = v.rdy[i];
      #1;
      e = sbq.pop_front();
      check($sformatf("vec%0d cyc%0d state/ctl", id, i), 32'({state, act_ctl}), 32'(e));
      @(posedge clk);
      #1;
    end
    if (v.cnt_inc) exp_cnt = exp_cnt + 16'd1;
    if (v.err) exp_err = 1'b1;
    check($sformatf("vec%0d instr_cnt", id), 32'(instr_cnt), 32'(exp_cnt));
    check($sformatf("vec%0d err_illegal", id), 32'(err_illegal), 32'(exp_err));
  endtask

  initial begin
    vecs[0]  = mkv(6'b100011, 4'd5, 32'h00043210, 8'h1F, 1'b1, 1'b0); // lw
    vecs[1]  = mkv(6'b101011, 4'd4, 32'h00005210, 8'h0F, 1'b1, 1'b0); // sw
    vecs[2]  = mkv(6'b000000, 4'd4, 32'h00007610, 8'h0F, 1'b1, 1'b0); // R-type
    vecs[3]  = mkv(6'b001000, 4'd4, 32'h0000BA10, 8'h0F, 1'b1, 1'b0); // addi
    vecs[4]  = mkv(6'b000100, 4'd3, 32'h00000810, 8'h07, 1'b1, 1'b0); // beq
    vecs[5]  = mkv(6'b000101, 4'd3, 32'h00000C10, 8'h07, 1'b1, 1'b0); // bne
    vecs[6]  = mkv(6'b000010, 4'd3, 32'h00000910, 8'h07, 1'b1, 1'b0); // j
    vecs[7]  = mkv(6'b000011, 4'd3, 32'h00000D10, 8'h07, 1'b1, 1'b0); // jal
    vecs[8]  = mkv(6'b111111, 4'd2, 32'h00000010, 8'h03, 1'b0, 1'b1); // illegal
    vecs[9]  = mkv(6'b000000, 4'd4, 32'h00007610, 8'h0F, 1'b1, 1'b0); // err stays set
    vecs[10] = mkv(6'b100011, 4'd7, 32'h04321000, 8'h7C, 1'b1, 1'b0); // lw, 2 fetch waits
    vecs[11] = mkv(6'b100011, 4'd6, 32'h00433210, 8'h37, 1'b1, 1'b0); // lw, 1 MEMRD wait
    vecs[12] = mkv(6'b000000, 4'd4, 32'h00007610, 8'h01, 1'b1, 1'b0); // ready ignored outside waits

    rst = 1'b1; rst2 = 1'b1;
    op = 6'b100011; mem_ready = 1'b1;
    op2 = 6'b001000; mem_ready2 = 1'b0;
    #2;
    check("reset state", 32'(state), 32'd0);
    check("reset ctl forced 0", 32'(act_ctl), 32'd0);
    check("reset cnt/err", 32'({instr_cnt, err_illegal}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 13; k++) run_vec(k, vecs[k]);

    // sw with two memory wait cycles in MEMWR: six cycles in total
    run_vec(20, mkv(6'b101011, 4'd6, 32'h00555210, 8'h27, 1'b1, 1'b0));
    check("back to FETCH", 32'(state), 32'd0);

    // Asynchronous reset while stalled in MEMRD
    op = 6'b100011; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1; mem_ready = 1'b0;
    #1; check("in MEMRD", 32'(state), 32'd3);
    rst = 1'b1;
    #1;
    check("async rst state", 32'(state), 32'd0);
    check("async rst ctl", 32'(act_ctl), 32'd0);
    check("async rst cnt/err", 32'({instr_cnt, err_illegal}), 32'd0);
    exp_cnt = '0; exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_vec(21, vecs[0]);

    // Base-ISA instance: addi is illegal, then the 4-bit counter wraps
    @(negedge clk);
    rst2 = 1'b0;
    #1; check("dut2 FETCH", 32'(state2), 32'd0);
    @(posedge clk); #1; check("dut2 DECODE", 32'(state2), 32'd1);
    @(posedge clk); #1; check("dut2 addi -> FETCH", 32'(state2), 32'd0);
    check("dut2 err set", 32'(err2), 32'd1);
    check("dut2 cnt unchanged", 32'(cnt2), 32'd0);
    op2 = 6'b000000;
    for (int k = 0; k < 16; k++) begin
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("dut2 Rtype%0d cnt", k), 32'({state2, cnt2}), 32'({4'd0, 4'(k + 1)}));
    end
    check("dut2 err sticky", 32'(err2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
